// File: rtl/red_pitaya_asg_seg_seq.sv
// Segment sequencer for the arbitrary signal generator: walks a list of
// table segments (start/end/step/repeat count) with a fractional pointer,
// using double-buffered configuration committed at sequence boundaries.
module red_pitaya_asg_seg_seq #(
  parameter int unsigned NSEG = 4,
  parameter int unsigned RSZ  = 14,
  parameter int unsigned FW   = 16,
  parameter int unsigned CW   = 16
) (
  input  logic           dac_clk_i,
  input  logic           dac_rstn_i,
  input  logic           cfg_we_i,
  input  logic [7:0]     cfg_addr_i,
  input  logic [31:0]    cfg_wdata_i,
  input  logic           trig_i,
  output logic [RSZ-1:0] rd_addr_o,
  output logic           rd_en_o,
  output logic [3:0]     seg_o,
  output logic [1:0]     state_o,
  output logic           trig_o,
  output logic           commit_pend_o
);

  localparam int unsigned PW       = RSZ + FW;
  localparam int unsigned SW       = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [3:0]  LAST_MAX = 4'(NSEG - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           trig_r_q, trig_r_d;
  logic           trig_p_q, trig_p_d;
  logic           hw_trig_q, hw_trig_d;
  logic           arm_q, arm_d;
  logic           stop_q, stop_d;
  logic           swtrig_q, swtrig_d;
  logic           pend_q, pend_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [3:0]     seg_q, seg_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           trig_out_q, trig_out_d;

  // Shadow bank (written by software) and active bank (used by the walker)
  logic [RSZ-1:0] sh_start_q [NSEG];
  logic [RSZ-1:0] sh_start_d [NSEG];
  logic [PW-1:0]  sh_end_q   [NSEG];
  logic [PW-1:0]  sh_end_d   [NSEG];
  logic [PW-1:0]  sh_step_q  [NSEG];
  logic [PW-1:0]  sh_step_d  [NSEG];
  logic [CW-1:0]  sh_ncyc_q  [NSEG];
  logic [CW-1:0]  sh_ncyc_d  [NSEG];
  logic           sh_loop_q, sh_loop_d;
  logic [3:0]     sh_last_q, sh_last_d;
  logic [RSZ-1:0] act_start_q [NSEG];
  logic [RSZ-1:0] act_start_d [NSEG];
  logic [PW-1:0]  act_end_q   [NSEG];
  logic [PW-1:0]  act_end_d   [NSEG];
  logic [PW-1:0]  act_step_q  [NSEG];
  logic [PW-1:0]  act_step_d  [NSEG];
  logic [CW-1:0]  act_ncyc_q  [NSEG];
  logic [CW-1:0]  act_ncyc_d  [NSEG];
  logic           act_loop_q, act_loop_d;
  logic [3:0]     act_last_q, act_last_d;

  logic           ctrl_wr;
  logic           seg_wr;
  logic [3:0]     seg_widx;
  logic [SW-1:0]  cur;
  logic [SW-1:0]  nidx;
  logic [PW:0]    nxt;
  logic [CW:0]    cyc_inc;
  logic [CW-1:0]  ncyc_eff;
  logic [RSZ-1:0] st0;
  logic           trig_ev;
  logic           seq_bound;
  logic           apply;

  // Config address decode and one-cycle control strobes
  always_comb begin
    ctrl_wr   = cfg_we_i && (cfg_addr_i == 8'h00);
    seg_widx  = 4'((cfg_addr_i - 8'h10) >> 2);
    seg_wr    = cfg_we_i && (cfg_addr_i >= 8'h10) && (cfg_addr_i < 8'h50)
                && (32'(seg_widx) < NSEG);
    arm_d     = ctrl_wr && cfg_wdata_i[0];
    stop_d    = ctrl_wr && cfg_wdata_i[1];
    swtrig_d  = ctrl_wr && cfg_wdata_i[3];
    trig_r_d  = trig_i;
    trig_p_d  = trig_r_q;
    hw_trig_d = trig_r_q && !trig_p_q;
  end

  // Sequencer FSM and fractional pointer walk
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    seg_d      = seg_q;
    cyc_d      = cyc_q;
    trig_out_d = 1'b0;
    seq_bound  = 1'b0;
    cur        = seg_q[SW-1:0];
    nidx       = SW'(seg_q + 4'd1);
    nxt        = {1'b0, ptr_q} + {1'b0, act_step_q[cur]};
    cyc_inc    = {1'b0, cyc_q} + (CW+1)'(1);
    ncyc_eff   = (act_ncyc_q[cur] == '0) ? CW'(1) : act_ncyc_q[cur];
    // a pending commit takes effect at the same edge that loads segment 0
    st0        = pend_q ? sh_start_q[0] : act_start_q[0];
    trig_ev    = hw_trig_q || swtrig_q;
    if (stop_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_q) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (trig_ev) begin
            state_d    = ST_RUN;
            ptr_d      = {st0, {FW{1'b0}}};
            seg_d      = '0;
            cyc_d      = '0;
            trig_out_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (nxt <= {1'b0, act_end_q[cur]}) begin
            ptr_d = nxt[PW-1:0];
          end else if (cyc_inc >= {1'b0, ncyc_eff}) begin
            if (seg_q == act_last_q) begin
              if (act_loop_q) begin
                seq_bound  = 1'b1;
                seg_d      = '0;
                cyc_d      = '0;
                ptr_d      = {st0, {FW{1'b0}}};
                trig_out_d = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              seg_d = seg_q + 4'd1;
              cyc_d = '0;
              ptr_d = {act_start_q[nidx], {FW{1'b0}}};
            end
          end else begin
            ptr_d = {act_start_q[cur], {FW{1'b0}}};
            cyc_d = cyc_inc[CW-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shadow writes, commit pending flag and shadow-to-active copy
  always_comb begin
    apply       = pend_q && ((state_q != ST_RUN) || seq_bound);
    sh_start_d  = sh_start_q;
    sh_end_d    = sh_end_q;
    sh_step_d   = sh_step_q;
    sh_ncyc_d   = sh_ncyc_q;
    sh_loop_d   = sh_loop_q;
    sh_last_d   = sh_last_q;
    act_start_d = act_start_q;
    act_end_d   = act_end_q;
    act_step_d  = act_step_q;
    act_ncyc_d  = act_ncyc_q;
    act_loop_d  = act_loop_q;
    act_last_d  = act_last_q;
    pend_d      = pend_q && !apply;
    if (apply) begin
      act_start_d = sh_start_q;
      act_end_d   = sh_end_q;
      act_step_d  = sh_step_q;
      act_ncyc_d  = sh_ncyc_q;
      act_loop_d  = sh_loop_q;
      act_last_d  = sh_last_q;
    end
    if (ctrl_wr) begin
      sh_loop_d = cfg_wdata_i[2];
      sh_last_d = (cfg_wdata_i[11:8] > LAST_MAX) ? LAST_MAX : cfg_wdata_i[11:8];
      if (cfg_wdata_i[4]) pend_d = 1'b1;
    end
    if (seg_wr) begin
      case (cfg_addr_i[1:0])
        2'd0:    sh_start_d[seg_widx[SW-1:0]] = RSZ'(cfg_wdata_i);
        2'd1:    sh_end_d[seg_widx[SW-1:0]]   = PW'(cfg_wdata_i);
        2'd2:    sh_step_d[seg_widx[SW-1:0]]  = PW'(cfg_wdata_i);
        default: sh_ncyc_d[seg_widx[SW-1:0]]  = CW'(cfg_wdata_i);
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_q    <= ST_IDLE;
      trig_r_q   <= 1'b0;
      trig_p_q   <= 1'b0;
      hw_trig_q  <= 1'b0;
      arm_q      <= 1'b0;
      stop_q     <= 1'b0;
      swtrig_q   <= 1'b0;
      pend_q     <= 1'b0;
      ptr_q      <= '0;
      seg_q      <= '0;
      cyc_q      <= '0;
      trig_out_q <= 1'b0;
      sh_loop_q  <= 1'b0;
      sh_last_q  <= '0;
      act_loop_q <= 1'b0;
      act_last_q <= '0;
      for (int unsigned i = 0; i < NSEG; i++) begin
        sh_start_q[i]  <= '0;
        sh_end_q[i]    <= '0;
        sh_step_q[i]   <= '0;
        sh_ncyc_q[i]   <= '0;
        act_start_q[i] <= '0;
        act_end_q[i]   <= '0;
        act_step_q[i]  <= '0;
        act_ncyc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      trig_r_q    <= trig_r_d;
      trig_p_q    <= trig_p_d;
      hw_trig_q   <= hw_trig_d;
      arm_q       <= arm_d;
      stop_q      <= stop_d;
      swtrig_q    <= swtrig_d;
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      seg_q       <= seg_d;
      cyc_q       <= cyc_d;
      trig_out_q  <= trig_out_d;
      sh_loop_q   <= sh_loop_d;
      sh_last_q   <= sh_last_d;
      act_loop_q  <= act_loop_d;
      act_last_q  <= act_last_d;
      sh_start_q  <= sh_start_d;
      sh_end_q    <= sh_end_d;
      sh_step_q   <= sh_step_d;
      sh_ncyc_q   <= sh_ncyc_d;
      act_start_q <= act_start_d;
      act_end_q   <= act_end_d;
      act_step_q  <= act_step_d;
      act_ncyc_q  <= act_ncyc_d;
    end
  end

  assign rd_addr_o     = ptr_q[PW-1:FW];
  assign rd_en_o       = (state_q == ST_RUN);
  assign seg_o         = seg_q;
  assign state_o       = state_q;
  assign trig_o        = trig_out_q;
  assign commit_pend_o = pend_q;

endmodule

// File: tb/tb_red_pitaya_asg_seg_seq.sv
// Directed bench for red_pitaya_asg_seg_seq; outputs sampled on the falling edge.
module tb_red_pitaya_asg_seg_seq;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        we    = 1'b0;
  logic [7:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic        trig  = 1'b0;
  logic [13:0] rd_addr;
  logic        rd_en;
  logic [3:0]  seg;
  logic [1:0]  st;
  logic        trg;
  logic        pend;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  red_pitaya_asg_seg_seq #(
    .NSEG(4),
    .RSZ (14),
    .FW  (16),
    .CW  (16)
  ) dut (
    .dac_clk_i    (clk),
    .dac_rstn_i   (rstn),
    .cfg_we_i     (we),
    .cfg_addr_i   (addr),
    .cfg_wdata_i  (wdata),
    .trig_i       (trig),
    .rd_addr_o    (rd_addr),
    .rd_en_o      (rd_en),
    .seg_o        (seg),
    .state_o      (st),
    .trig_o       (trg),
    .commit_pend_o(pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One config write, captured by the rising edge between the two falling edges
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic expect_run(input string tag, input logic [13:0] a, input logic [3:0] s,
                            input logic t);
    @(negedge clk);
    check({tag, ".st"},   32'(st),      32'd2);
    check({tag, ".en"},   32'(rd_en),   32'd1);
    check({tag, ".addr"}, 32'(rd_addr), 32'(a));
    check({tag, ".seg"},  32'(seg),     32'(s));
    check({tag, ".trg"},  32'(trg),     32'(t));
  endtask

  task automatic expect_idle(input string tag, input logic [1:0] s, input logic [13:0] a);
    check({tag, ".st"},   32'(st),      32'(s));
    check({tag, ".en"},   32'(rd_en),   32'd0);
    check({tag, ".addr"}, 32'(rd_addr), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    expect_idle("rst", 2'd0, 14'd0);
    check("rst.seg",  32'(seg),  32'd0);
    check("rst.trg",  32'(trg),  32'd0);
    check("rst.pend", 32'(pend), 32'd0);
    rstn = 1'b1;

    // Single segment, two passes, no loop
    wr(8'h10, 32'd3);
    wr(8'h11, 32'd5 << 16);
    wr(8'h12, 32'd1 << 16);
    wr(8'h13, 32'd2);
    wr(8'h00, 32'h10);
    check("t1.pend_set", 32'(pend), 32'd1);
    @(negedge clk);
    check("t1.pend_clr", 32'(pend), 32'd0);
    wr(8'h00, 32'h1);
    @(negedge clk);
    check("t1.armed", 32'(st), 32'd1);
    wr(8'h00, 32'h8);
    check("t1.sw_lat", 32'(st), 32'd1);
    expect_run("t1.a0", 14'd3, 4'd0, 1'b1);
    expect_run("t1.a1", 14'd4, 4'd0, 1'b0);
    expect_run("t1.a2", 14'd5, 4'd0, 1'b0);
    expect_run("t1.a3", 14'd3, 4'd0, 1'b0);
    expect_run("t1.a4", 14'd4, 4'd0, 1'b0);
    expect_run("t1.a5", 14'd5, 4'd0, 1'b0);
    @(negedge clk);
    expect_idle("t1.done", 2'd3, 14'd5);

    // Two segments back to back, last_seg=1
    wr(8'h10, 32'd0);
    wr(8'h11, 32'd1 << 16);
    wr(8'h12, 32'd1 << 16);
    wr(8'h13, 32'd1);
    wr(8'h14, 32'h100);
    wr(8'h15, 32'h101 << 16);
    wr(8'h16, 32'd1 << 16);
    wr(8'h17, 32'd1);
    wr(8'h00, 32'h111);
    @(negedge clk);
    check("t2.armed", 32'(st),   32'd1);
    check("t2.pend",  32'(pend), 32'd0);
    wr(8'h00, 32'h108);
    expect_run("t2.a0", 14'h000, 4'd0, 1'b1);
    expect_run("t2.a1", 14'h001, 4'd0, 1'b0);
    expect_run("t2.a2", 14'h100, 4'd1, 1'b0);
    expect_run("t2.a3", 14'h101, 4'd1, 1'b0);
    @(negedge clk);
    expect_idle("t2.done", 2'd3, 14'h101);
    check("t2.done.seg", 32'(seg), 32'd1);

    // Fractional step with loop: end is 3.5 so address 3 appears twice
    wr(8'h10, 32'd0);
    wr(8'h11, 32'h38000);
    wr(8'h12, 32'h8000);
    wr(8'h13, 32'd1);
    wr(8'h00, 32'h15);
    @(negedge clk);
    check("t3.armed", 32'(st), 32'd1);
    wr(8'h00, 32'h0C);
    expect_run("t3.a0", 14'd0, 4'd0, 1'b1);
    expect_run("t3.a1", 14'd0, 4'd0, 1'b0);
    expect_run("t3.a2", 14'd1, 4'd0, 1'b0);
    expect_run("t3.a3", 14'd1, 4'd0, 1'b0);
    expect_run("t3.a4", 14'd2, 4'd0, 1'b0);
    expect_run("t3.a5", 14'd2, 4'd0, 1'b0);
    expect_run("t3.a6", 14'd3, 4'd0, 1'b0);
    expect_run("t3.a7", 14'd3, 4'd0, 1'b0);
    expect_run("t3.wrap", 14'd0, 4'd0, 1'b1);

    // Commit during RUN is deferred to the sequence boundary
    wr(8'h10, 32'h20);
    wr(8'h00, 32'h14);
    check("t4.pend_set", 32'(pend), 32'd1);
    check("t4.old4", 32'(rd_addr), 32'd2);
    expect_run("t4.old5", 14'd2, 4'd0, 1'b0);
    expect_run("t4.old6", 14'd3, 4'd0, 1'b0);
    expect_run("t4.old7", 14'd3, 4'd0, 1'b0);
    check("t4.pend_hold", 32'(pend), 32'd1);
    expect_run("t4.new0", 14'h20, 4'd0, 1'b1);
    check("t4.pend_clr", 32'(pend), 32'd0);
    // end below start: one address per pass, every pass a boundary
    expect_run("t4.new1", 14'h20, 4'd0, 1'b1);

    // Stop and arm together: stop wins
    wr(8'h00, 32'h07);
    @(negedge clk);
    expect_idle("t5.stop", 2'd0, 14'h20);
    trig = 1'b1;
    repeat (4) @(negedge clk);
    check("t5.trig_ign", 32'(st), 32'd0);
    trig = 1'b0;

    // Hardware trigger latency, then reset mid-RUN with trig_i held high
    wr(8'h00, 32'h05);
    @(negedge clk);
    check("t6.armed", 32'(st), 32'd1);
    trig = 1'b1;
    @(negedge clk);
    check("t6.lat1", 32'(st), 32'd1);
    @(negedge clk);
    check("t6.lat2", 32'(st), 32'd1);
    expect_run("t6.run", 14'h20, 4'd0, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    expect_idle("t6.rst", 2'd0, 14'd0);
    check("t6.rst.seg",  32'(seg),  32'd0);
    check("t6.rst.trg",  32'(trg),  32'd0);
    check("t6.rst.pend", 32'(pend), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    wr(8'h00, 32'h1);
    @(negedge clk);
    check("t6.rearm", 32'(st), 32'd1);
    repeat (4) @(negedge clk);
    check("t6.no_start", 32'(st), 32'd1);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    trig = 1'b1;
    repeat (2) @(negedge clk);
    check("t6.edge_lat", 32'(st), 32'd1);
    expect_run("t6.fresh", 14'd0, 4'd0, 1'b1);
    // all-zero bank: step 0 repeats start indefinitely
    repeat (4) @(negedge clk);
    expect_run("t6.step0", 14'd0, 4'd0, 1'b0);
    wr(8'h00, 32'h2);
    @(negedge clk);
    expect_idle("t6.stop", 2'd0, 14'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
